// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and baud divider helper
// for the oversampling UART receiver.
package uart_pkg;

   localparam int CHK_NONE = 0;
   localparam int CHK_ODD  = 1;
   localparam int CHK_EVEN = 2;

   localparam int ERR_PARITY = 0;
   localparam int ERR_FRAME  = 1;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK_WAIT
   } rx_state_t;

   function automatic int calc_div(
      input int clk_hz,
      input int baud,
      input int os
   );
      return clk_hz / (baud * os);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full
// is accepted only if a pop frees the head slot in that cycle.
module uart_rx_fifo #(
   parameter int P_WIDTH = 10,
   parameter int P_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic [P_WIDTH-1:0] i_data,
   output logic               o_full,
   input  logic               i_pop,
   output logic [P_WIDTH-1:0] o_data,
   output logic               o_empty
);

   localparam int AW = $clog2(P_DEPTH);

   logic [P_WIDTH-1:0] mem_q [P_DEPTH];
   logic [AW-1:0]      wr_ptr_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [AW:0]        count_q;
   logic               wr_en;
   logic               rd_en;

   assign o_empty = (count_q == '0);
   assign o_full  = (count_q == (AW+1)'(P_DEPTH));
   assign rd_en   = i_pop && !o_empty;
   assign wr_en   = i_push && (!o_full || rd_en);
   assign o_data  = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (rd_en) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-vote sampling, parity,
// framing and break detection, FIFO output with valid/ready.
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int P_SYSTEM_CLK      = 50_000_000,
   parameter int P_UART_BAUD_RATE  = 9600,
   parameter int P_OVERSAMPLE      = 16,
   parameter int P_UART_DATA_WIDTH = 8,
   parameter int P_UART_STOP_WIDTH = 1,
   parameter int P_UART_CHECK      = 0,
   parameter int P_FIFO_DEPTH      = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_uart_rx,
   output logic [P_UART_DATA_WIDTH-1:0] o_rx_data,
   output logic [1:0]                   o_rx_err,
   output logic                         o_rx_valid,
   input  logic                         i_rx_ready,
   output logic                         o_overflow,
   output logic                         o_break
);

   localparam int DIV = calc_div(P_SYSTEM_CLK, P_UART_BAUD_RATE,
                                 P_OVERSAMPLE);
   localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SW  = $clog2(P_OVERSAMPLE);
   localparam int W   = P_UART_DATA_WIDTH;
   localparam int BW  = $clog2(W + 1);
   localparam int FW  = W + 2;

   localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
   localparam logic [SW-1:0] S_V0      = SW'(P_OVERSAMPLE/2 - 1);
   localparam logic [SW-1:0] S_V1      = SW'(P_OVERSAMPLE/2);
   localparam logic [SW-1:0] S_DEC     = SW'(P_OVERSAMPLE/2 + 1);
   localparam logic [SW-1:0] S_LAST    = SW'(P_OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST    = BW'(W);
   localparam logic [BW-1:0] STOP_LAST = BW'(P_UART_STOP_WIDTH - 1);

   if (DIV < 1) begin : g_chk_div
      $error("uart_rx_os: clock too slow for baud*oversample");
   end
   if (P_OVERSAMPLE != 8 && P_OVERSAMPLE != 16) begin : g_chk_os
      $error("uart_rx_os: oversample must be 8 or 16");
   end
   if (W < 5 || W > 9) begin : g_chk_w
      $error("uart_rx_os: data width must be 5..9");
   end

   logic            rx_meta_q;
   logic            rx_s_q;
   logic [1:0]      warm_q;
   logic [TW-1:0]   tick_cnt_q;
   rx_state_t       state_q, state_d;
   logic [SW-1:0]   samp_q, samp_d;
   logic [1:0]      votes_q, votes_d;
   logic [W-1:0]    data_q, data_d;
   logic [BW-1:0]   bitc_q, bitc_d;
   logic            par_q, par_d;
   logic            perr_q, perr_d;
   logic            ferr_q, ferr_d;

   logic            tick;
   logic            start_det;
   logic            maj;
   logic            ones_odd;
   logic            ferr_now;
   logic            is_break;
   logic            frame_end;
   logic            push;
   logic            pop;
   logic            full;
   logic            empty;
   logic [1:0]      err;
   logic [FW-1:0]   head;

   // The synchroniser resets to idle-high; warm_q keeps WAIT_IDLE
   // from trusting that reset value instead of the real pin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         warm_q    <= 2'b00;
      end else begin
         rx_meta_q <= i_uart_rx;
         rx_s_q    <= rx_meta_q;
         warm_q    <= {warm_q[0], 1'b1};
      end
   end

   assign start_det = (state_q == IDLE) && !rx_s_q;
   assign tick      = (tick_cnt_q == TICK_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt_q <= '0;
      end else if (start_det || tick) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_q + 1'b1;
      end
   end

   assign maj = (votes_q[0] & votes_q[1]) |
                (votes_q[0] & rx_s_q) |
                (votes_q[1] & rx_s_q);

   assign ones_odd  = (^data_q) ^ maj;
   assign ferr_now  = ferr_q | ~maj;
   assign is_break  = ferr_now && (data_q == '0) &&
                      (P_UART_CHECK == CHK_NONE || !par_q);
   assign frame_end = (state_q == STOP) && tick &&
                      (samp_q == S_DEC) && (bitc_q == STOP_LAST);
   assign push      = frame_end && !is_break;
   assign o_break   = frame_end && is_break;

   always_comb begin
      state_d = state_q;
      samp_d  = samp_q;
      votes_d = votes_q;
      data_d  = data_q;
      bitc_d  = bitc_q;
      par_d   = par_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      unique case (state_q)
         WAIT_IDLE: begin
            if (warm_q[1] && rx_s_q) state_d = IDLE;
         end
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               samp_d  = '0;
               bitc_d  = '0;
               par_d   = 1'b0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end
         end
         BREAK_WAIT: begin
            if (rx_s_q) state_d = IDLE;
         end
         default: begin
            if (tick) begin
               samp_d = samp_q + 1'b1;
               if (samp_q == S_V0) votes_d[0] = rx_s_q;
               if (samp_q == S_V1) votes_d[1] = rx_s_q;
               if (samp_q == S_DEC) begin
                  unique case (state_q)
                     START: if (maj) state_d = IDLE;
                     DATA: begin
                        data_d = {maj, data_q[W-1:1]};
                        bitc_d = bitc_q + 1'b1;
                     end
                     PARITY: begin
                        par_d  = maj;
                        perr_d = (P_UART_CHECK == CHK_ODD) ?
                                 !ones_odd : ones_odd;
                     end
                     default: begin
                        if (!maj) ferr_d = 1'b1;
                        if (bitc_q == STOP_LAST) begin
                           state_d = is_break ? BREAK_WAIT : IDLE;
                        end else begin
                           bitc_d = bitc_q + 1'b1;
                        end
                     end
                  endcase
               end
               if (samp_q == S_LAST) begin
                  unique case (state_q)
                     START: begin
                        state_d = DATA;
                        bitc_d  = '0;
                     end
                     DATA: begin
                        if (bitc_q == B_LAST) begin
                           state_d = (P_UART_CHECK != CHK_NONE) ?
                                     PARITY : STOP;
                           bitc_d  = '0;
                        end
                     end
                     PARITY: begin
                        state_d = STOP;
                        bitc_d  = '0;
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WAIT_IDLE;
         samp_q  <= '0;
         votes_q <= 2'b11;
         data_q  <= '0;
         bitc_q  <= '0;
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         samp_q  <= samp_d;
         votes_q <= votes_d;
         data_q  <= data_d;
         bitc_q  <= bitc_d;
         par_q   <= par_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      err             = 2'b00;
      err[ERR_PARITY] = perr_q;
      err[ERR_FRAME]  = ferr_now;
   end

   assign pop        = o_rx_valid && i_rx_ready;
   assign o_overflow = push && full && !pop;

   uart_rx_fifo #(
      .P_WIDTH (FW),
      .P_DEPTH (P_FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (push),
      .i_data  ({err, data_q}),
      .o_full  (full),
      .i_pop   (pop),
      .o_data  (head),
      .o_empty (empty)
   );

   assign o_rx_valid = !empty;
   assign o_rx_data  = o_rx_valid ? head[W-1:0] : '0;
   assign o_rx_err   = o_rx_valid ? head[FW-1:W] : '0;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os in 8E2, 16x oversample,
// one bit = 16 clk, FIFO depth 4.
module tb_uart_rx_os;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       ready;
   logic [7:0] rx_data;
   logic [1:0] rx_err;
   logic       rx_valid;
   logic       overflow;
   logic       brk;

   int total = 0;
   int bad   = 0;
   int ovf_cnt = 0;
   int brk_cnt = 0;

   always #5 clk = ~clk;

   uart_rx_os #(
      .P_SYSTEM_CLK      (16_000_000),
      .P_UART_BAUD_RATE  (1_000_000),
      .P_OVERSAMPLE      (16),
      .P_UART_DATA_WIDTH (8),
      .P_UART_STOP_WIDTH (2),
      .P_UART_CHECK      (2),
      .P_FIFO_DEPTH      (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .i_uart_rx  (rx),
      .o_rx_data  (rx_data),
      .o_rx_err   (rx_err),
      .o_rx_valid (rx_valid),
      .i_rx_ready (ready),
      .o_overflow (overflow),
      .o_break    (brk)
   );

   always @(negedge clk) begin
      if (overflow) ovf_cnt++;
      if (brk) brk_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   task automatic drive_bit(input logic b, input int n);
      rx = b;
      repeat (n) @(negedge clk);
   endtask

   // 8E2 frame; v_mid = o_rx_valid at the end of stop bit 1
   task automatic send_frame(input logic [7:0] d,
                             input logic par_inv,
                             input logic s1_low,
                             output logic v_mid);
      drive_bit(1'b0, 16);
      for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
      drive_bit((^d) ^ par_inv, 16);
      drive_bit(!s1_low, 16);
      v_mid = rx_valid;
      drive_bit(1'b1, 16);
   endtask

   task automatic pop_one();
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      rx    = 1'b1;
      ready = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if ({rx_valid, rx_data, rx_err, overflow, brk} !== 13'h0) begin
         bad++;
         $display("FAIL reset_outs got=%b want=0",
                  {rx_valid, rx_data, rx_err, overflow, brk});
      end
      rst = 1'b0;
      drive_bit(1'b1, 40);
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle valid got=%b want=0", rx_valid);
      end
   endtask

   task automatic test_good_frame();
      logic vm;
      send_frame(8'h0A, 1'b0, 1'b0, vm);
      total++;
      if (vm !== 1'b0) begin
         bad++;
         $display("FAIL t1_early valid got=%b want=0", vm);
      end
      total++;
      if ({rx_valid, rx_data, rx_err} !== {1'b1, 8'h0A, 2'b00}) begin
         bad++;
         $display("FAIL t1_entry got v=%b d=%h e=%b want v=1 d=0a e=00",
                  rx_valid, rx_data, rx_err);
      end
      pop_one();
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL t1_drain valid got=%b want=0", rx_valid);
      end
   endtask

   task automatic test_parity_err();
      logic vm;
      send_frame(8'hA5, 1'b1, 1'b0, vm);
      total++;
      if ({rx_valid, rx_data, rx_err} !== {1'b1, 8'hA5, 2'b01}) begin
         bad++;
         $display("FAIL t2_parity got v=%b d=%h e=%b want v=1 d=a5 e=01",
                  rx_valid, rx_data, rx_err);
      end
      pop_one();
   endtask

   task automatic test_frame_err();
      logic vm;
      send_frame(8'h3C, 1'b0, 1'b1, vm);
      total++;
      if ({rx_valid, rx_data, rx_err} !== {1'b1, 8'h3C, 2'b10}) begin
         bad++;
         $display("FAIL t3_frame got v=%b d=%h e=%b want v=1 d=3c e=10",
                  rx_valid, rx_data, rx_err);
      end
      pop_one();
   endtask

   task automatic test_glitch();
      logic vm;
      drive_bit(1'b0, 4);
      drive_bit(1'b1, 48);
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL t4_glitch valid got=%b want=0", rx_valid);
      end
      send_frame(8'h55, 1'b0, 1'b0, vm);
      total++;
      if ({rx_valid, rx_data, rx_err} !== {1'b1, 8'h55, 2'b00}) begin
         bad++;
         $display("FAIL t4_entry got v=%b d=%h e=%b want v=1 d=55 e=00",
                  rx_valid, rx_data, rx_err);
      end
      pop_one();
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL t4_single valid got=%b want=0", rx_valid);
      end
   endtask

   task automatic test_overflow();
      logic vm;
      int   base;
      logic [7:0] want;
      ready = 1'b0;
      base  = ovf_cnt;
      for (int i = 1; i <= 4; i++) begin
         want = 8'(i);
         send_frame(want, 1'b0, 1'b0, vm);
      end
      total++;
      if (ovf_cnt - base !== 0) begin
         bad++;
         $display("FAIL t5_no_ovf got=%0d want=0", ovf_cnt - base);
      end
      send_frame(8'h05, 1'b0, 1'b0, vm);
      total++;
      if (ovf_cnt - base !== 1) begin
         bad++;
         $display("FAIL t5_ovf pulses got=%0d want=1", ovf_cnt - base);
      end
      ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         want = 8'(i);
         total++;
         if ({rx_valid, rx_data} !== {1'b1, want}) begin
            bad++;
            $display("FAIL t5_read%0d got v=%b d=%h want v=1 d=%h",
                     i, rx_valid, rx_data, want);
         end
         @(negedge clk);
      end
      ready = 1'b0;
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL t5_empty valid got=%b want=0", rx_valid);
      end
   endtask

   task automatic test_break();
      logic vm;
      int   base;
      base = brk_cnt;
      drive_bit(1'b0, 20 * 16);
      drive_bit(1'b1, 32);
      total++;
      if ({brk_cnt - base, rx_valid} !== {32'd1, 1'b0}) begin
         bad++;
         $display("FAIL t6_break got pulses=%0d v=%b want pulses=1 v=0",
                  brk_cnt - base, rx_valid);
      end
      send_frame(8'h7E, 1'b0, 1'b0, vm);
      total++;
      if ({rx_valid, rx_data, rx_err} !== {1'b1, 8'h7E, 2'b00}) begin
         bad++;
         $display("FAIL t6_after_brk got v=%b d=%h e=%b want v=1 d=7e e=00",
                  rx_valid, rx_data, rx_err);
      end
      pop_one();
   endtask

   task automatic test_reset_mid();
      logic vm;
      drive_bit(1'b0, 16);
      for (int i = 0; i < 3; i++) drive_bit(1'b1, 16);
      drive_bit(1'b0, 8);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      drive_bit(1'b0, 40);
      drive_bit(1'b1, 48);
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL t6_rst_mid valid got=%b want=0", rx_valid);
      end
      send_frame(8'h81, 1'b0, 1'b0, vm);
      total++;
      if ({rx_valid, rx_data, rx_err} !== {1'b1, 8'h81, 2'b00}) begin
         bad++;
         $display("FAIL t6_after_rst got v=%b d=%h e=%b want v=1 d=81 e=00",
                  rx_valid, rx_data, rx_err);
      end
      pop_one();
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("FAIL t6_final valid got=%b want=0", rx_valid);
      end
   endtask

   initial begin
      rst   = 1'b1;
      rx    = 1'b1;
      ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_good_frame();
      test_parity_err();
      test_frame_err();
      test_glitch();
      test_overflow();
      test_break();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
